// File: rtl/spi_accel_slave_if.sv
// SPI pin bundle between the accelerometer controller (master) and the
// register-map responder (slave).
`timescale 1ns / 1ps
interface spi_accel_slave_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output cs, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input cs, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_accel_slave.sv
// SPI responder modelling an X/Y/Z accelerometer register map: WHO_AM_I,
// a writable CTRL_REG1 and shadowed 16-bit sample registers.
`timescale 1ns / 1ps
module spi_accel_slave #(
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h68,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_accel_slave_if.slave      spi,
  input  logic [15:0]           sample_x,
  input  logic [15:0]           sample_y,
  input  logic [15:0]           sample_z,
  input  logic                  sample_valid,
  output logic [7:0]            ctrl_reg1_out,
  output logic                  wr_valid,
  output logic [5:0]            wr_addr,
  output logic [7:0]            wr_data
);

  localparam logic [5:0] CtrlAddr = 6'h10;

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic [2:0]             bit_cnt_q;
  logic [6:0]             shift_q;
  logic [7:0]             tx_q;
  logic [5:0]             addr_q;
  logic                   rd_q, ms_q;
  logic                   miso_q, miso_oe_q;
  logic [7:0]             ctrl_q;
  logic                   wr_valid_q;
  logic [5:0]             wr_addr_q;
  logic [7:0]             wr_data_q;
  logic [15:0]            x_q, y_q, z_q, px_q, py_q, pz_q;
  logic                   pend_q;

  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [7:0] in_byte;
  logic [5:0] addr_step, rd_addr;
  logic [7:0] rd_data;

  // Synchronizers reset low so a cs held low across reset never looks like a fresh frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  assign in_byte   = {shift_q, mosi_s};
  assign addr_step = ms_q ? addr_q + 6'd1 : addr_q;
  // At command close the address comes straight from the byte being completed.
  assign rd_addr   = (state_q == StCmd) ? in_byte[5:0] : addr_step;

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      6'h0F:   rd_data = WHO_AM_I_VAL;
      CtrlAddr: rd_data = ctrl_q;
      6'h28:   rd_data = x_q[7:0];
      6'h29:   rd_data = x_q[15:8];
      6'h2A:   rd_data = y_q[7:0];
      6'h2B:   rd_data = y_q[15:8];
      6'h2C:   rd_data = z_q[7:0];
      6'h2D:   rd_data = z_q[15:8];
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      ms_q       <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      ctrl_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      if (cs_rise) begin
        // Any partial byte is dropped here: no commit, no address step.
        state_q   <= StIdle;
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cs_fall) begin
              state_q   <= StCmd;
              bit_cnt_q <= '0;
              miso_q    <= 1'b0;
              miso_oe_q <= 1'b1;
            end
          end
          StCmd: begin
            if (sclk_rise) begin
              shift_q   <= in_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= StData;
                rd_q    <= in_byte[7];
                ms_q    <= in_byte[6];
                addr_q  <= in_byte[5:0];
                tx_q    <= in_byte[7] ? rd_data : 8'h00;
              end
            end
            if (sclk_fall) miso_q <= 1'b0;
          end
          StData: begin
            if (sclk_rise) begin
              shift_q   <= in_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (!rd_q && addr_q == CtrlAddr) begin
                  ctrl_q     <= in_byte;
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= addr_q;
                  wr_data_q  <= in_byte;
                end
                addr_q <= addr_step;
                tx_q   <= rd_q ? rd_data : 8'h00;
              end
            end
            if (sclk_fall) begin
              miso_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Sample shadowing: live in IDLE, otherwise held pending until cs rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      px_q   <= '0;
      py_q   <= '0;
      pz_q   <= '0;
      pend_q <= 1'b0;
    end else if (sample_valid && (state_q == StIdle || cs_rise)) begin
      x_q    <= sample_x;
      y_q    <= sample_y;
      z_q    <= sample_z;
      pend_q <= 1'b0;
    end else if (cs_rise && pend_q) begin
      x_q    <= px_q;
      y_q    <= py_q;
      z_q    <= pz_q;
      pend_q <= 1'b0;
    end else if (sample_valid) begin
      px_q   <= sample_x;
      py_q   <= sample_y;
      pz_q   <= sample_z;
      pend_q <= 1'b1;
    end
  end

  assign spi.miso      = miso_q;
  assign spi.miso_oe   = miso_oe_q;
  assign ctrl_reg1_out = ctrl_q;
  assign wr_valid      = wr_valid_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;

endmodule
